pipeline_delay_line: RTL
========================

# pipeline_delay_line

Parametrised multi-stage pipeline register for the DSP datapath that generalises the single-stage selectable register. It delays a `reg_size`-bit word and its valid flag by `DEPTH` clock-enabled cycles. It supports combinational bypass and a valid-only flush. It sits between DSP arithmetic stages (pre-adder, multiplier, post-adder) wherever more than one register of latency is required.

## Interface
- `reg_size`, 18: data width in bits (≥1).
- `DEPTH`, 2: number of register stages (≥1).
- `CLK` input 1: clock; all state updates on rising edge.
- `RST` input 1: reset, synchronous, active-high; clears all data and valid stages.
- `CE` input 1: clock enable; 0 holds every stage.
- `SEL` input 1: 1 = registered path, 0 = combinational bypass.
- `FLUSH` input 1: synchronous clear of valid bits only.
- `D_in` input `reg_size`: data in.
- `VLD_in` input 1: data-in valid.
- `D_out` output `reg_size`: data out.
- `VLD_out` output 1: data-out valid.
- `OCC` output `$clog2(DEPTH+1)`: count of valid words held (only with `PIPE_OCC_EN`).

## Operation
- Internal state is stages 0..DEPTH-1, each holding `data[s]` and `vld[s]`. Stage 0 loads from `D_in`/`VLD_in`, and stage s loads from stage s-1.
- Update priority per rising edge:
  - RST clears all data, vld and OCC to 0.
  - Otherwise FLUSH clears all vld to 0, including the incoming word. Data shifts if CE=1 and holds otherwise. OCC goes to 0.
  - Otherwise CE=1 shifts data and vld by one stage.
  - Otherwise everything holds.
- Output mux:
  - SEL=1: `D_out` = `data[DEPTH-1]` and `VLD_out` = `vld[DEPTH-1]`.
  - SEL=0: `D_out` = `D_in` and `VLD_out` = `VLD_in` (combinational).
- The registers keep shifting regardless of SEL. Toggling SEL never disturbs pipeline contents.
- Data is not qualified by valid. Invalid stages still carry and shift data, so a bubble passes through whatever data is on `D_in`.
- OCC update on a CE=1 shift: OCC + `VLD_in` − `vld[DEPTH-1]`. It never overflows, because OCC is always ≤ DEPTH.
- Reset values of the registered path are `D_out`=0, `VLD_out`=0, OCC=0. In bypass, the outputs follow the inputs even during reset.

## Timing
- Latency with SEL=1 is DEPTH CE-qualified edges from `D_in` to `D_out`. With CE held at 1, a word presented before edge k appears at `D_out` after edge k+DEPTH−1.
- Latency with SEL=0 is 0 cycles.
- With CE=0, outputs are stable for the whole stall, regardless of DEPTH.
- For DEPTH=1 the block behaves as a single register with a valid flag.
- RST asserted mid-stream discards all in-flight words on that edge. The first word after RST deasserts emerges DEPTH enabled edges later.
- FLUSH and CE on the same edge: data shifts, all vld are 0, and OCC is 0.
- RST and FLUSH together: RST governs.

## Configuration
- `PIPE_OCC_EN` defined: the OCC port and its counter exist, updated as in Operation.
- `PIPE_OCC_EN` undefined: no OCC port and no counter logic. All other behaviour is identical.

## Structure
- Shared package `dsp_pipe_pkg`:
  - localparams for default `reg_size`/`DEPTH`.
  - function `occ_width(depth)` returning `$clog2(depth+1)`, with a minimum of 1.
- Sub-module `pipeline_stage`: one data+valid register with CE, synchronous RST and FLUSH. It is instantiated DEPTH times via a generate loop.
- The top level holds the output mux and the OCC counter.

## Test plan
- Reset: RST=1 for 2 cycles with `D_in`=0x3FFFF and VLD_in=1, SEL=1 → `D_out`=0, `VLD_out`=0, OCC=0.
- Latency: DEPTH=3, CE=1, drive 1,2,3,… with VLD_in=1 → `D_out`=1 appears 3 edges after first sample; OCC saturates at 3.
- Stall: CE=0 for 4 cycles mid-stream → `D_out`/`VLD_out`/OCC frozen; the sequence resumes without loss or duplication.
- Bypass: SEL toggled 1→0→1 while streaming 0x00A5 → SEL=0 outputs equal the inputs the same cycle; SEL=1 resumes the delayed sequence unchanged.
- Flush: pipeline full (OCC=3), FLUSH=1 with CE=1 and VLD_in=1 → next cycle all vld=0, OCC=0, `VLD_out`=0 for 3 edges.
- Priority: RST=1 and FLUSH=1 together on a full pipeline → all data and valid 0. Compare against a bench with `PIPE_OCC_EN` undefined and confirm identical `D_out`/`VLD_out`.

Source files
------------

// File: rtl/dsp_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_pkg
// Shared definitions for the DSP datapath pipeline registers.
//   DEF_REG_SIZE : default data width of a pipeline word
//   DEF_DEPTH    : default number of register stages
//   occ_width()  : width of an occupancy counter that can hold 0..depth
//                  (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package dsp_pipe_pkg;

  localparam int DEF_REG_SIZE = 18;
  localparam int DEF_DEPTH    = 2;

  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : dsp_pipe_pkg

// File: rtl/pipeline_stage.sv
// -----------------------------------------------------------------------------
// pipeline_stage
// One data + valid register of the delay line.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears data and valid
//   ce       : clock enable; 1 loads d_in/vld_in, 0 holds
//   flush    : synchronous clear of the valid bit only (data still follows ce)
//   d_in     : data from the previous stage (or the block input)
//   vld_in   : valid from the previous stage (or the block input)
//   d_out    : registered data
//   vld_out  : registered valid
// -----------------------------------------------------------------------------
module pipeline_stage
  import dsp_pipe_pkg::*;
#(
  parameter int reg_size = DEF_REG_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                flush,
  input  logic [reg_size-1:0] d_in,
  input  logic                vld_in,
  output logic [reg_size-1:0] d_out,
  output logic                vld_out
);

  logic [reg_size-1:0] data_q, data_d;
  logic                vld_q,  vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (ce) begin
      data_d = d_in;
      vld_d  = vld_in;
    end
    // Flush kills validity whether or not the stage shifts; data is never
    // qualified by valid, so it keeps following ce.
    if (flush) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_out   = data_q;
  assign vld_out = vld_q;

endmodule : pipeline_stage

// File: rtl/pipeline_delay_line.sv
// -----------------------------------------------------------------------------
// pipeline_delay_line
// Delays a reg_size-bit word and its valid flag by DEPTH clock-enabled cycles,
// with a combinational bypass and a valid-only flush.
// Optional feature macro: PIPE_OCC_EN (adds the OCC port and its counter).
// Ports:
//   CLK     : clock, rising edge
//   RST     : synchronous active-high reset, clears every stage (and OCC)
//   CE      : clock enable; 0 holds every stage
//   SEL     : 1 = registered (delayed) output, 0 = combinational bypass
//   FLUSH   : synchronous clear of all valid bits, including the incoming word
//   D_in    : data in
//   VLD_in  : data-in valid
//   D_out   : data out
//   VLD_out : data-out valid
//   OCC     : number of valid words held in the stages (PIPE_OCC_EN only)
// Valid semantics: there is no back-pressure. VLD_in only marks D_in as a
// meaningful word; data moves whenever CE=1 irrespective of valid, and VLD_out
// marks which words leaving the line are meaningful.
// -----------------------------------------------------------------------------
module pipeline_delay_line
  import dsp_pipe_pkg::*;
#(
  parameter int reg_size = DEF_REG_SIZE,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           CE,
  input  logic                           SEL,
  input  logic                           FLUSH,
  input  logic [reg_size-1:0]            D_in,
  input  logic                           VLD_in,
  output logic [reg_size-1:0]            D_out,
  output logic                           VLD_out
`ifdef PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0]    OCC
`endif
);

  // Index 0 is the block input; index s+1 is the output of stage s.
  logic [reg_size-1:0] stage_data [DEPTH+1];
  logic                stage_vld  [DEPTH+1];

  assign stage_data[0] = D_in;
  assign stage_vld[0]  = VLD_in;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    pipeline_stage #(
      .reg_size (reg_size)
    ) u_stage (
      .clk     (CLK),
      .rst     (RST),
      .ce      (CE),
      .flush   (FLUSH),
      .d_in    (stage_data[s]),
      .vld_in  (stage_vld[s]),
      .d_out   (stage_data[s+1]),
      .vld_out (stage_vld[s+1])
    );
  end

  // The stages shift regardless of SEL, so toggling the bypass never
  // disturbs words in flight.
  always_comb begin
    D_out   = stage_data[0];
    VLD_out = stage_vld[0];
    if (SEL) begin
      D_out   = stage_data[DEPTH];
      VLD_out = stage_vld[DEPTH];
    end
  end

`ifdef PIPE_OCC_EN
  localparam int OccW = occ_width(DEPTH);

  logic [OccW-1:0] occ_q, occ_d;

  // One word enters and one leaves per enabled edge, so the count stays in
  // 0..DEPTH and the modular add/subtract never wraps.
  always_comb begin
    occ_d = occ_q;
    if (FLUSH) begin
      occ_d = '0;
    end else if (CE) begin
      occ_d = occ_q + OccW'(VLD_in) - OccW'(stage_vld[DEPTH]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;
`endif

endmodule : pipeline_delay_line
